addr_reg_bank: RTL

//  Bank of NUM_CH independent address registers (AR/PC-style pointers) with load, clear, increment
//  and decrement by a fixed STEP. Optional per-channel circular mode bounded by [base, limit].

---
 rtl/addr_reg_pkg.sv | 9 +
 rtl/addr_step_unit.sv | 28 ++
 rtl/addr_reg_bank.sv | 90 +++++++++
 3 files changed

// File: rtl/addr_reg_pkg.sv
// addr_reg_pkg: shared op encoding, reset constants and channel-index width helper
package addr_reg_pkg;
  typedef enum logic [2:0] {OP_NONE, OP_CLR, OP_LOAD, OP_INC, OP_DEC} op_e;
  localparam logic RST_CIRC = 1'b0;
  localparam logic RST_FLAG = 1'b0;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/addr_step_unit.sv
// addr_step_unit: next pointer and wrap for one inc/dec step in linear or circular mode
//  ptr_i/base_i/limit_i/circ_i: channel state; op_i: decoded op
//  next_ptr_o: pointer after the op (ptr_i unless OP_INC/OP_DEC); wrap_o: op wrapped
module addr_step_unit import addr_reg_pkg::*; #(
  parameter int WIDTH = 12,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] ptr_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             circ_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] next_ptr_o,
  output logic             wrap_o
);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  logic [WIDTH:0] inc_w, dec_lo;
  logic inc_wrap, dec_wrap;
  // one extra bit keeps carry and base+STEP visible
  assign inc_w    = {1'b0, ptr_i} + STEP_W;
  assign dec_lo   = circ_i ? {1'b0, base_i} + STEP_W : STEP_W;
  assign inc_wrap = circ_i ? (inc_w > {1'b0, limit_i}) : inc_w[WIDTH];
  assign dec_wrap = {1'b0, ptr_i} < dec_lo;
  assign next_ptr_o = (op_i == OP_INC) ? ((circ_i && inc_wrap) ? base_i : inc_w[WIDTH-1:0]) :
                      (op_i == OP_DEC) ? ((circ_i && dec_wrap) ? limit_i : ptr_i - STEP_W[WIDTH-1:0]) :
                      ptr_i;
  assign wrap_o = (op_i == OP_INC && inc_wrap) || (op_i == OP_DEC && dec_wrap);
endmodule

// File: rtl/addr_reg_bank.sv
// addr_reg_bank: bank of NUM_CH address pointers with load/clear/inc/dec and circular wrap
//  sel selects the channel for ops and cfg; addr_out is its pointer (0 if sel out of range)
//  addr_all exposes every pointer; wrap_pulse flags a wrap on the previous edge; wrap_sticky per channel
module addr_reg_bank import addr_reg_pkg::*; #(
  parameter int WIDTH  = 12,
  parameter int NUM_CH = 4,
  parameter int STEP   = 1,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CH_W-1:0]         sel,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    increment,
  input  logic                    decrement,
  input  logic [WIDTH-1:0]        DATA_in,
  input  logic                    cfg_we,
  input  logic [WIDTH-1:0]        cfg_base,
  input  logic [WIDTH-1:0]        cfg_limit,
  input  logic                    cfg_circ,
  output logic [WIDTH-1:0]        addr_out,
  output logic [NUM_CH*WIDTH-1:0] addr_all,
  output logic                    wrap_pulse,
  output logic [NUM_CH-1:0]       wrap_sticky
);
  logic [NUM_CH-1:0][WIDTH-1:0] ptr_q, ptr_d, base_q, base_d, limit_q, limit_d;
  logic [NUM_CH-1:0] circ_q, circ_d, sticky_q, sticky_d;
  logic pulse_q, sel_ok, wrap;
  logic [WIDTH-1:0] next_ptr;
  op_e op;
  assign sel_ok = int'(sel) < NUM_CH;
  assign op = !sel_ok ? OP_NONE :
              clr ? OP_CLR :
              load ? OP_LOAD :
              (increment && !decrement) ? OP_INC :
              (decrement && !increment) ? OP_DEC : OP_NONE;
  // one step unit shared across channels through the sel mux
  addr_step_unit #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .ptr_i     (sel_ok ? ptr_q[sel] : '0),
    .base_i    (sel_ok ? base_q[sel] : '0),
    .limit_i   (sel_ok ? limit_q[sel] : '0),
    .circ_i    (sel_ok && circ_q[sel]),
    .op_i      (op),
    .next_ptr_o(next_ptr),
    .wrap_o    (wrap)
  );
  always_comb begin
    ptr_d    = ptr_q;
    base_d   = base_q;
    limit_d  = limit_q;
    circ_d   = circ_q;
    sticky_d = sticky_q;
    if (op == OP_CLR) begin
      ptr_d[sel]    = '0;
      sticky_d[sel] = 1'b0;
    end else if (op == OP_LOAD) begin
      ptr_d[sel] = DATA_in;
    end else if (op == OP_INC || op == OP_DEC) begin
      ptr_d[sel]    = next_ptr;
      sticky_d[sel] = sticky_q[sel] | wrap;
    end
    if (sel_ok && cfg_we) begin
      base_d[sel]  = cfg_base;
      limit_d[sel] = cfg_limit;
      circ_d[sel]  = cfg_circ;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      base_q   <= '0;
      limit_q  <= '1;
      circ_q   <= {NUM_CH{RST_CIRC}};
      sticky_q <= {NUM_CH{RST_FLAG}};
      pulse_q  <= RST_FLAG;
    end else begin
      ptr_q    <= ptr_d;
      base_q   <= base_d;
      limit_q  <= limit_d;
      circ_q   <= circ_d;
      sticky_q <= sticky_d;
      pulse_q  <= wrap;
    end
  end
  assign addr_out    = sel_ok ? ptr_q[sel] : '0;
  assign addr_all    = ptr_q;
  assign wrap_pulse  = pulse_q;
  assign wrap_sticky = sticky_q;
endmodule
